// File: rtl/ac97_pkg.sv
// Shared AC'97 register map, fixed command words and sequencer states
// for the LM4550 PCM controller.
package ac97_pkg;

  localparam logic [7:0] REG_RESET    = 8'h00;
  localparam logic [7:0] REG_HP_VOL   = 8'h04;
  localparam logic [7:0] REG_PCM_VOL  = 8'h18;
  localparam logic [7:0] REG_REC_SEL  = 8'h1A;
  localparam logic [7:0] REG_REC_GAIN = 8'h1C;
  localparam logic [7:0] REG_MIC_VOL  = 8'h0E;
  localparam logic [7:0] REG_GP       = 8'h20;
  localparam logic [7:0] REG_VRA_CTRL = 8'h2A;
  localparam logic [7:0] REG_DAC_RATE = 8'h2C;
  localparam logic [7:0] REG_ADC_RATE = 8'h32;
  localparam logic [7:0] RD_FLAG      = 8'h80;

  localparam logic [15:0] VRA_ON     = 16'h0001;
  localparam logic [15:0] PCM_VOL_W  = 16'h0808;
  localparam logic [15:0] REC_GAIN_W = 16'h0F0F;
  localparam logic [15:0] MIC_VOL_W  = 16'h8048;
  localparam logic [15:0] GP_W       = 16'h8000;

  typedef enum logic [3:0] {
    INIT0, INIT1, INIT2, INIT3, INIT4,
    INIT5, INIT6, INIT7, INIT8, INIT9,
    IDLE, UPD_VOL, UPD_SRC
  } seq_e;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } cmd_t;

  // Codec attenuation is inverted: 0 means loudest.
  function automatic logic [15:0] vol_word(input logic [4:0] v);
    logic [4:0] a;
    a = 5'd31 - v;
    return {3'b000, a, 3'b000, a};
  endfunction

  function automatic logic [15:0] src_word(input logic [2:0] s);
    return {5'b00000, s, 5'b00000, s};
  endfunction

endpackage

// File: rtl/ac97_pcm_ctrl_if.sv
// PCM sample stream between the audio datapath and the AC'97
// controller: playback valid/ready plus capture strobe.
interface ac97_pcm_ctrl_if #(
  parameter int W = 16
) ();
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] in_data;
  logic         in_valid;

  modport master (
    output out_data, out_valid,
    input  out_ready, in_data, in_valid
  );

  modport slave (
    input  out_data, out_valid,
    output out_ready, in_data, in_valid
  );
endinterface

// File: rtl/ac97_pcm_ctrl_fifo.sv
// Playback sample FIFO; reading while empty yields zero so the
// slot registers load silence on underflow.
module pcm_sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ac97_pcm_ctrl.sv
// LM4550 AC'97 controller: codec reset, init/update command
// sequencer, buffered playback and capture sample paths.
module ac97_pcm_ctrl
  import ac97_pkg::*;
#(
  parameter int          WIDTH        = 16,
  parameter int          CHANNELS     = 1,
  parameter logic [15:0] SAMPLE_RATE  = 16'd8000,
  parameter int          FIFO_DEPTH   = 16,
  parameter int          RESET_CYCLES = 1024
) (
  input  logic        clock_27mhz,
  input  logic        reset,
  input  logic [4:0]  volume,
  input  logic [2:0]  source,
  input  logic        frame_ready,
  input  logic        slot_req,
  input  logic [19:0] left_in_data,
  input  logic [19:0] right_in_data,
  output logic [19:0] left_out_data,
  output logic [19:0] right_out_data,
  output logic [7:0]  command_address,
  output logic [15:0] command_data,
  output logic        command_valid,
  output logic        audio_reset_b,
  output logic        init_done,
  output logic        underflow,
  ac97_pcm_ctrl_if.slave pcm
);
  localparam int SW  = CHANNELS * WIDTH;
  localparam int RCW = $clog2(RESET_CYCLES) + 1;

  logic [RCW-1:0]   rst_cnt;
  logic [2:0]       sync_q;
  logic             frame_tick;
  logic             sample_tick;
  seq_e             state_q;
  seq_e             state_d;
  cmd_t             cmd;
  logic [4:0]       vol_q;
  logic [2:0]       src_q;
  logic             push;
  logic             full;
  logic             empty;
  logic [SW-1:0]    fifo_dout;
  logic [WIDTH-1:0] chan_l;
  logic [WIDTH-1:0] chan_r;
  logic [WIDTH+19:0] l_ext;
  logic [WIDTH+19:0] r_ext;
  logic [SW-1:0]    cap;
  logic [SW-1:0]    in_data_q;
  logic             in_valid_q;
  logic             unused_ok;

  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      rst_cnt       <= '0;
      audio_reset_b <= 1'b0;
    end else if (!audio_reset_b) begin
      if (rst_cnt == RCW'(RESET_CYCLES - 1)) audio_reset_b <= 1'b1;
      else rst_cnt <= rst_cnt + 1'b1;
    end
  end

  always_ff @(posedge clock_27mhz) begin
    if (reset) sync_q <= '0;
    else sync_q <= {sync_q[1:0], frame_ready};
  end

  assign frame_tick  = sync_q[1] & ~sync_q[2] & audio_reset_b;
  assign sample_tick = frame_tick & slot_req & init_done;

  always_ff @(posedge clock_27mhz) begin
    if (reset) state_q <= INIT0;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cmd     = '{RD_FLAG | REG_RESET, 16'h0000};
    unique case (state_q)
      INIT1:            cmd = '{REG_VRA_CTRL, VRA_ON};
      INIT2:            cmd = '{REG_DAC_RATE, SAMPLE_RATE};
      INIT3:            cmd = '{REG_ADC_RATE, SAMPLE_RATE};
      INIT4, UPD_VOL:   cmd = '{REG_HP_VOL, vol_word(volume)};
      INIT5:            cmd = '{REG_PCM_VOL, PCM_VOL_W};
      INIT6, UPD_SRC:   cmd = '{REG_REC_SEL, src_word(source)};
      INIT7:            cmd = '{REG_REC_GAIN, REC_GAIN_W};
      INIT8:            cmd = '{REG_MIC_VOL, MIC_VOL_W};
      INIT9:            cmd = '{REG_GP, GP_W};
      default:          ;
    endcase
    if (frame_tick) begin
      if (state_q == INIT9 || state_q == UPD_VOL ||
          state_q == UPD_SRC)
        state_d = IDLE;
      else if (state_q != IDLE)
        state_d = seq_e'(state_q + 4'd1);
    end
    // Volume wins when both differ; source follows a frame later.
    if (state_q == IDLE) begin
      if (volume != vol_q)      state_d = UPD_VOL;
      else if (source != src_q) state_d = UPD_SRC;
    end
  end

  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      command_address <= RD_FLAG | REG_RESET;
      command_data    <= '0;
      command_valid   <= 1'b0;
      vol_q           <= '0;
      src_q           <= '0;
      init_done       <= 1'b0;
    end else if (frame_tick) begin
      command_address <= cmd.addr;
      command_data    <= cmd.data;
      command_valid   <= 1'b1;
      if (state_q == INIT4 || state_q == UPD_VOL) vol_q <= volume;
      if (state_q == INIT6 || state_q == UPD_SRC) src_q <= source;
      if (state_q == INIT9) init_done <= 1'b1;
    end
  end

  assign pcm.out_ready = ~full & ~reset;
  assign push = pcm.out_valid & pcm.out_ready;

  pcm_sample_fifo #(
    .DATA_W (SW),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock_27mhz),
    .reset (reset),
    .push  (push),
    .pop   (sample_tick),
    .din   (pcm.out_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  // Mono: both slices alias the same bits, so right mirrors left.
  assign chan_l = fifo_dout[SW-1 -: WIDTH];
  assign chan_r = fifo_dout[WIDTH-1:0];
  assign l_ext  = {chan_l, 20'd0};
  assign r_ext  = {chan_r, 20'd0};

  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      left_out_data  <= '0;
      right_out_data <= '0;
      underflow      <= 1'b0;
    end else begin
      underflow <= sample_tick & empty;
      if (sample_tick) begin
        left_out_data  <= l_ext[WIDTH+19 -: 20];
        right_out_data <= r_ext[WIDTH+19 -: 20];
      end
    end
  end

  generate
    if (CHANNELS == 2) begin : g_stereo
      assign cap = {left_in_data[19 -: WIDTH],
                    right_in_data[19 -: WIDTH]};
    end else begin : g_mono
      assign cap = left_in_data[19 -: WIDTH];
    end
  endgenerate

  assign unused_ok = ^{left_in_data, right_in_data};

  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
    end else begin
      in_valid_q <= sample_tick;
      if (sample_tick) in_data_q <= cap;
    end
  end

  assign pcm.in_data  = in_data_q;
  assign pcm.in_valid = in_valid_q;

endmodule

// File: tb/tb_ac97_pcm_ctrl.sv
// Scoreboard bench: mono/16-bit/8 kHz and stereo/20-bit/48 kHz
// controllers driven by a shared frame engine model.
module tb_ac97_pcm_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  volume;
  logic [2:0]  source;
  logic        frame_ready;
  logic        slot_req;
  logic [19:0] left_in;
  logic [19:0] right_in;

  logic [19:0] a_left, a_right, b_left, b_right;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic        a_valid, b_valid, a_arb, b_arb;
  logic        a_done, b_done, a_uf, b_uf;

  ac97_pcm_ctrl_if #(.W(16)) pcm_a ();
  ac97_pcm_ctrl_if #(.W(40)) pcm_b ();

  always #5 clk = ~clk;

  ac97_pcm_ctrl dut_a (
    .clock_27mhz     (clk),
    .reset           (reset),
    .volume          (volume),
    .source          (source),
    .frame_ready     (frame_ready),
    .slot_req        (slot_req),
    .left_in_data    (left_in),
    .right_in_data   (right_in),
    .left_out_data   (a_left),
    .right_out_data  (a_right),
    .command_address (a_addr),
    .command_data    (a_data),
    .command_valid   (a_valid),
    .audio_reset_b   (a_arb),
    .init_done       (a_done),
    .underflow       (a_uf),
    .pcm             (pcm_a)
  );

  ac97_pcm_ctrl #(
    .WIDTH        (20),
    .CHANNELS     (2),
    .SAMPLE_RATE  (16'd48000),
    .FIFO_DEPTH   (4),
    .RESET_CYCLES (16)
  ) dut_b (
    .clock_27mhz     (clk),
    .reset           (reset),
    .volume          (volume),
    .source          (source),
    .frame_ready     (frame_ready),
    .slot_req        (slot_req),
    .left_in_data    (left_in),
    .right_in_data   (right_in),
    .left_out_data   (b_left),
    .right_out_data  (b_right),
    .command_address (b_addr),
    .command_data    (b_data),
    .command_valid   (b_valid),
    .audio_reset_b   (b_arb),
    .init_done       (b_done),
    .underflow       (b_uf),
    .pcm             (pcm_b)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic [19:0] la, ra, lb, rb;
    int          uf;
    logic        done;
  } exp_t;

  exp_t        exp_q [$];
  logic [15:0] cap_a_q [$];
  logic [39:0] cap_b_q [$];

  int checks = 0;
  int errors = 0;
  int uf_seen = 0;
  logic frame_done = 1'b0;
  logic prev_iv_a = 1'b0;

  logic [19:0] e_la, e_ra, e_lb, e_rb;
  int          e_uf;
  logic        e_done, e_samp;
  logic [15:0] e_cap_a;
  logic [39:0] e_cap_b;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (frame_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_sb: got no entry expected one");
      end else begin
        e = exp_q.pop_front();
        chk("cmd_addr_a", a_addr, e.addr);
        chk("cmd_data_a", a_data, e.data_a);
        chk("cmd_addr_b", b_addr, e.addr);
        chk("cmd_data_b", b_data, e.data_b);
        chk("cmd_valid_a", a_valid, 1);
        chk("left_a", a_left, e.la);
        chk("right_a", a_right, e.ra);
        chk("left_b", b_left, e.lb);
        chk("right_b", b_right, e.rb);
        chk("underflow_cnt", uf_seen, e.uf);
        chk("init_done_a", a_done, e.done);
      end
    end
    if (a_uf) uf_seen++;
    if (pcm_a.in_valid) begin
      chk("in_valid_pulse", prev_iv_a, 0);
      if (cap_a_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cap_a: got %0h expected none", pcm_a.in_data);
      end else chk("in_data_a", pcm_a.in_data, cap_a_q.pop_front());
    end
    if (pcm_b.in_valid) begin
      if (cap_b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cap_b: got %0h expected none", pcm_b.in_data);
      end else chk("in_data_b", pcm_b.in_data, cap_b_q.pop_front());
    end
    prev_iv_a <= pcm_a.in_valid;
  end

  task automatic frame(input logic [7:0] ea, input logic [15:0] da,
                       input logic [15:0] db);
    exp_t e;
    e.addr = ea;  e.data_a = da; e.data_b = db;
    e.la = e_la;  e.ra = e_ra;   e.lb = e_lb; e.rb = e_rb;
    e.uf = e_uf;  e.done = e_done;
    exp_q.push_back(e);
    if (e_samp) begin
      cap_a_q.push_back(e_cap_a);
      cap_b_q.push_back(e_cap_b);
    end
    frame_ready = 1'b1;
    repeat (6) @(posedge clk);
    frame_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1 frame_done = 1'b1;
    @(posedge clk);
    #1 frame_done = 1'b0;
  endtask

  task automatic init_seq(input logic [15:0] vw, input logic [15:0] sw);
    logic [7:0]  ad [10];
    logic [15:0] dd [10];
    ad = '{8'h80, 8'h2A, 8'h2C, 8'h32, 8'h04,
           8'h18, 8'h1A, 8'h1C, 8'h0E, 8'h20};
    dd = '{16'h0000, 16'h0001, 16'h1F40, 16'h1F40, vw,
           16'h0808, sw, 16'h0F0F, 16'h8048, 16'h8000};
    e_samp = 1'b0;
    for (int i = 0; i < 10; i++) begin
      e_done = (i == 9);
      frame(ad[i], dd[i], (i == 2 || i == 3) ? 16'hBB80 : dd[i]);
    end
  endtask

  initial begin
    reset = 1'b1;
    volume = 5'd31;
    source = 3'd0;
    frame_ready = 1'b0;
    slot_req = 1'b0;
    left_in = 20'hFEDCB;
    right_in = 20'h13579;
    pcm_a.out_data = '0;
    pcm_a.out_valid = 1'b0;
    pcm_b.out_data = '0;
    pcm_b.out_valid = 1'b0;
    e_la = '0; e_ra = '0; e_lb = '0; e_rb = '0;
    e_uf = 0; e_done = 1'b0; e_samp = 1'b0;
    e_cap_a = 16'hFEDC;
    e_cap_b = {20'hFEDCB, 20'h13579};

    @(posedge clk);
    #1;
    chk("rst_addr", a_addr, 8'h80);
    chk("rst_data", a_data, 16'h0000);
    chk("rst_valid", a_valid, 0);
    chk("rst_arb", a_arb, 0);
    chk("rst_done", a_done, 0);
    chk("rst_left", a_left, 0);
    chk("rst_uf", a_uf, 0);
    chk("rst_in_valid", pcm_a.in_valid, 0);
    chk("rst_in_data", pcm_a.in_data, 0);
    reset = 1'b0;

    repeat (1023) @(posedge clk);
    #1 chk("arb_1023", a_arb, 0);
    @(posedge clk);
    #1 chk("arb_1024", a_arb, 1);
    repeat (76) @(posedge clk);
    #1;

    slot_req = 1'b1;
    init_seq(16'h0000, 16'h0000);

    pcm_b.out_data = {20'hABCDE, 20'h12345};
    pcm_b.out_valid = 1'b1;
    @(posedge clk);
    #1 pcm_b.out_valid = 1'b0;
    e_samp = 1'b1;
    e_lb = 20'hABCDE; e_rb = 20'h12345;
    e_uf = 1;
    frame(8'h80, 16'h0000, 16'h0000);

    for (int i = 0; i < 16; i++) begin
      pcm_a.out_data = 16'(16'h1000 + i);
      pcm_a.out_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("out_ready_full", pcm_a.out_ready, 0);
    pcm_a.out_data = 16'hDEAD;
    @(posedge clk);
    #1 pcm_a.out_valid = 1'b0;
    chk("out_ready_still_full", pcm_a.out_ready, 0);
    e_la = 20'h10000; e_ra = 20'h10000;
    e_lb = '0; e_rb = '0;
    frame(8'h80, 16'h0000, 16'h0000);
    chk("out_ready_after_pop", pcm_a.out_ready, 1);
    for (int i = 1; i < 16; i++) begin
      if (i == 8) begin
        left_in = 20'h12345;
        e_cap_a = 16'h1234;
        e_cap_b = {20'h12345, 20'h13579};
      end
      e_la = {16'(16'h1000 + i), 4'h0};
      e_ra = e_la;
      frame(8'h80, 16'h0000, 16'h0000);
    end

    slot_req = 1'b0;
    e_samp = 1'b0;
    frame(8'h80, 16'h0000, 16'h0000);
    slot_req = 1'b1;
    e_samp = 1'b1;
    e_la = '0; e_ra = '0;
    e_uf = 2;
    frame(8'h80, 16'h0000, 16'h0000);
    e_uf = 3;
    frame(8'h80, 16'h0000, 16'h0000);

    slot_req = 1'b0;
    e_samp = 1'b0;
    volume = 5'd0;
    source = 3'd1;
    frame(8'h04, 16'h1F1F, 16'h1F1F);
    frame(8'h1A, 16'h0101, 16'h0101);
    frame(8'h80, 16'h0000, 16'h0000);

    for (int i = 0; i < 2; i++) begin
      pcm_a.out_data = 16'(16'h5555 + i);
      pcm_a.out_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    pcm_a.out_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_done", a_done, 0);
    chk("mid_rst_arb", a_arb, 0);
    chk("mid_rst_addr", a_addr, 8'h80);
    chk("mid_rst_valid", a_valid, 0);
    reset = 1'b0;
    repeat (1000) @(posedge clk);
    #1 chk("arb_restart_hold", a_arb, 0);
    repeat (40) @(posedge clk);
    #1;
    e_uf = 3;
    slot_req = 1'b1;
    init_seq(16'h1F1F, 16'h0101);
    e_samp = 1'b1;
    e_uf = 4;
    frame(8'h80, 16'h0000, 16'h0000);

    repeat (5) @(posedge clk);
    #1;
    chk("frame_sb_drained", exp_q.size(), 0);
    chk("cap_a_drained", cap_a_q.size(), 0);
    chk("cap_b_drained", cap_b_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
